cgra_config_loader: RTL

//  Host-side initiator for the elastic CGRA config-load and execution-param interface.

---
 rtl/cgra_config_loader_if.sv | 62 ++++++
 rtl/cgra_config_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cgra_config_loader_if.sv
// Config-record stream and registered config bus between host and loader.
// Host side uses master, loader uses slave.
interface cgra_config_loader_if #(
  parameter int PE_ROW_SIZE     = 4,
  parameter int PE_COLUMN_SIZE  = 4,
  parameter int NEIGHBOR_PE_NUM = 4,
  parameter int INPUT_NUM_W     = 3,
  parameter int OP_W            = 5,
  parameter int DATA_WIDTH      = 32,
  parameter int CONTEXT_SIZE    = 16
);
  // one spare bit so out-of-range targets can be expressed and rejected
  localparam int ROW_W = $clog2(PE_ROW_SIZE + 1);
  localparam int COL_W = $clog2(PE_COLUMN_SIZE + 1);
  localparam int CTX_W = $clog2(CONTEXT_SIZE + 1);

  logic                       cfg_valid;
  logic                       cfg_ready;
  logic                       cfg_last;
  logic [ROW_W-1:0]           cfg_row;
  logic [COL_W-1:0]           cfg_col;
  logic [INPUT_NUM_W-1:0]     cfg_in1;
  logic [INPUT_NUM_W-1:0]     cfg_in2;
  logic [NEIGHBOR_PE_NUM-1:0] cfg_out;
  logic [OP_W-1:0]            cfg_op;
  logic [DATA_WIDTH-1:0]      cfg_const;
  logic [CTX_W-1:0]           cfg_ctx;

  logic [ROW_W-1:0]           config_PE_row_index;
  logic [COL_W-1:0]           config_PE_column_index;
  logic [INPUT_NUM_W-1:0]     config_input_PE_index_1;
  logic [INPUT_NUM_W-1:0]     config_input_PE_index_2;
  logic [NEIGHBOR_PE_NUM-1:0] config_output_PE_index;
  logic [OP_W-1:0]            config_op;
  logic [DATA_WIDTH-1:0]      config_const_data;
  logic [CTX_W-1:0]           config_index;
  logic                       write_config_data;

  modport master (
    output cfg_valid, cfg_last, cfg_row, cfg_col,
    output cfg_in1, cfg_in2, cfg_out, cfg_op,
    output cfg_const, cfg_ctx,
    input  cfg_ready,
    input  config_PE_row_index, config_PE_column_index,
    input  config_input_PE_index_1, config_input_PE_index_2,
    input  config_output_PE_index, config_op,
    input  config_const_data, config_index,
    input  write_config_data
  );

  modport slave (
    input  cfg_valid, cfg_last, cfg_row, cfg_col,
    input  cfg_in1, cfg_in2, cfg_out, cfg_op,
    input  cfg_const, cfg_ctx,
    output cfg_ready,
    output config_PE_row_index, config_PE_column_index,
    output config_input_PE_index_1, config_input_PE_index_2,
    output config_output_PE_index, config_op,
    output config_const_data, config_index,
    output write_config_data
  );
endinterface

// File: rtl/cgra_config_loader.sv
// Host-side CGRA config loader: writes per-PE context records,
// then starts execution and times the run.
module cgra_config_loader #(
  parameter int PE_ROW_SIZE     = 4,
  parameter int PE_COLUMN_SIZE  = 4,
  parameter int NEIGHBOR_PE_NUM = 4,
  parameter int INPUT_NUM_W     = 3,
  parameter int OP_W            = 5,
  parameter int DATA_WIDTH      = 32,
  parameter int CONTEXT_SIZE    = 16,
  parameter int CYCLE_W         = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                load_req,
  input  logic [CYCLE_W-1:0]                  exec_cycles,
  cgra_config_loader_if.slave                 cfg,
  output logic                                start_exec,
  output logic [$clog2(CONTEXT_SIZE+1)-1:0]   mapping_context_max_id,
  output logic                                busy,
  output logic                                done,
  output logic                                err_range,
  output logic [15:0]                         record_count
);
  localparam int ROW_W = $clog2(PE_ROW_SIZE + 1);
  localparam int COL_W = $clog2(PE_COLUMN_SIZE + 1);
  localparam int CTX_W = $clog2(CONTEXT_SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_WRITE, S_START, S_RUN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ROW_W-1:0]           row_q;
  logic [COL_W-1:0]           col_q;
  logic [INPUT_NUM_W-1:0]     in1_q, in2_q;
  logic [NEIGHBOR_PE_NUM-1:0] out_q;
  logic [OP_W-1:0]            op_q;
  logic [DATA_WIDTH-1:0]      const_q;
  logic [CTX_W-1:0]           ctx_q;
  logic                       last_q;
  logic [15:0]                cnt_q;
  logic [CTX_W-1:0]           max_id_q, max_nx, map_q;
  logic                       err_q;
  logic [CYCLE_W-1:0]         cyc_q;

  logic hs, legal;

  assign hs    = (state_q == S_ACCEPT) && cfg.cfg_valid;
  assign legal = (cfg.cfg_row < ROW_W'(PE_ROW_SIZE))
              && (cfg.cfg_col < COL_W'(PE_COLUMN_SIZE))
              && (cfg.cfg_ctx < CTX_W'(CONTEXT_SIZE));

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (load_req) state_d = S_ACCEPT;
      S_ACCEPT: begin
        if (hs) begin
          if (legal)
            state_d = S_WRITE;
          else if (cfg.cfg_last)
            state_d = (cnt_q != 16'd0) ? S_START : S_DONE;
        end
      end
      S_WRITE:  state_d = last_q ? S_START : S_ACCEPT;
      S_START:  state_d = S_RUN;
      S_RUN:    if (cyc_q == '0) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // strobes and status decoded from the current state
  always_comb begin
    cfg.cfg_ready         = 1'b0;
    cfg.write_config_data = 1'b0;
    start_exec            = 1'b0;
    done                  = 1'b0;
    busy                  = (state_q != S_IDLE);
    unique case (state_q)
      S_ACCEPT: cfg.cfg_ready         = 1'b1;
      S_WRITE:  cfg.write_config_data = 1'b1;
      S_START:  start_exec            = 1'b1;
      S_DONE:   done                  = 1'b1;
      default:  ;
    endcase
  end

  // running max including the record being written this cycle
  always_comb begin
    max_nx = max_id_q;
    if (state_q == S_WRITE && ctx_q > max_id_q) max_nx = ctx_q;
  end

  // record capture, counters and session status
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q    <= '0;
      col_q    <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      out_q    <= '0;
      op_q     <= '0;
      const_q  <= '0;
      ctx_q    <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      max_id_q <= '0;
      map_q    <= '0;
      err_q    <= 1'b0;
      cyc_q    <= '0;
    end else begin
      if (state_q == S_IDLE && load_req) begin
        cnt_q    <= '0;
        max_id_q <= '0;
        map_q    <= '0;
        err_q    <= 1'b0;
      end
      if (hs && legal) begin
        row_q   <= cfg.cfg_row;
        col_q   <= cfg.cfg_col;
        in1_q   <= cfg.cfg_in1;
        in2_q   <= cfg.cfg_in2;
        out_q   <= cfg.cfg_out;
        op_q    <= cfg.cfg_op;
        const_q <= cfg.cfg_const;
        ctx_q   <= cfg.cfg_ctx;
        last_q  <= cfg.cfg_last;
      end
      if (hs && !legal) err_q <= 1'b1;
      if (state_q == S_WRITE) begin
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        max_id_q <= max_nx;
      end
      // published on entry so it is valid alongside start_exec
      if (state_d == S_START && state_q != S_START) map_q <= max_nx;
      if (state_q == S_START)
        cyc_q <= exec_cycles;
      else if (state_q == S_RUN && cyc_q != '0)
        cyc_q <= cyc_q - 1'b1;
    end
  end

  assign cfg.config_PE_row_index     = row_q;
  assign cfg.config_PE_column_index  = col_q;
  assign cfg.config_input_PE_index_1 = in1_q;
  assign cfg.config_input_PE_index_2 = in2_q;
  assign cfg.config_output_PE_index  = out_q;
  assign cfg.config_op               = op_q;
  assign cfg.config_const_data       = const_q;
  assign cfg.config_index            = ctx_q;
  assign mapping_context_max_id      = map_q;
  assign err_range                   = err_q;
  assign record_count                = cnt_q;
endmodule
